// File: rtl/cfg_byte_writer_pkg.sv
// Shared definitions for the byte-serial config link (host writer and synth-side decode).
package cfg_link_pkg;

  localparam int unsigned CFG_STROBE_BIT = 7;
  localparam int unsigned CFG_ADDR0_BIT  = 0;
  localparam int unsigned CFG_ADDR_LSB   = 1;
  localparam int unsigned CFG_ADDR_BITS  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } cfg_state_e;

  typedef struct packed {
    logic [CFG_ADDR_BITS-1:0] addr;
    logic [1:0]               be;
    logic [15:0]              data;
  } cfg_entry_t;

  // Largest of the three phase lengths; sizes the shared down-counter.
  function automatic int unsigned cfg_max3(input int unsigned a, input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/cfg_byte_writer_if.sv
// Word-write request channel into the config byte writer.
interface cfg_byte_writer_if #(
  parameter int unsigned ADDR_BITS = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [ADDR_BITS-1:0] in_addr;
  logic [15:0]          in_data;
  logic [1:0]           in_be;

  modport master (output in_valid, output in_addr, output in_data, output in_be, input in_ready);
  modport slave  (input in_valid, input in_addr, input in_data, input in_be, output in_ready);
endinterface

// File: rtl/cfg_byte_writer_fifo.sv
// Small synchronous FIFO with first-word fall-through read and full/empty flags.
module cfg_fifo #(
  parameter int unsigned WIDTH     = 21,
  parameter int unsigned FIFO_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 32'd1 << FIFO_LOG2;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [FIFO_LOG2:0] wr_ptr_q;
  logic [FIFO_LOG2:0] rd_ptr_q;
  logic               do_push;
  logic               do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                   (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr_q[FIFO_LOG2-1:0]];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[FIFO_LOG2-1:0]] <= wdata;
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (FIFO_LOG2+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (FIFO_LOG2+1)'(1);
    end
  end

endmodule

// File: rtl/cfg_byte_writer.sv
// Host-side config writer: buffers word writes and emits each enabled byte as a
// setup / strobe / hold transfer on the synth's ui_in / uio_in pins.
module cfg_byte_writer
  import cfg_link_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 3,
  parameter int unsigned FIFO_LOG2     = 2,
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  cfg_byte_writer_if.slave    wr,
  output logic [7:0]          cfg_ctrl,
  output logic [7:0]          cfg_data,
  output logic                busy
);

  // ADDR_BITS must leave bit 7 free for the strobe (ADDR_BITS <= 6).
  localparam int unsigned ENTRY_W = ADDR_BITS + 2 + 16;
  localparam int unsigned MAX_CYC = cfg_max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  logic [ENTRY_W-1:0]   push_entry;
  logic [ENTRY_W-1:0]   pop_entry;
  logic [ADDR_BITS-1:0] pop_addr;
  logic [1:0]           pop_be;
  logic [15:0]          pop_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push_c;
  logic                 pop_c;

  cfg_state_e           state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic                 phase_q,   phase_d;
  logic                 hi_en_q,   hi_en_d;
  logic [7:0]           hi_byte_q, hi_byte_d;
  logic [7:0]           ctrl_d;
  logic [7:0]           data_d;

  assign push_entry = {wr.in_addr, wr.in_be, wr.in_data};
  assign {pop_addr, pop_be, pop_data} = pop_entry;
  assign push_c      = wr.in_valid & ~fifo_full;
  assign wr.in_ready = ~fifo_full;
  assign busy        = ~fifo_empty | (state_q != ST_IDLE);

  cfg_fifo #(
    .WIDTH     (ENTRY_W),
    .FIFO_LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .wdata (push_entry),
    .pop   (pop_c),
    .rdata (pop_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, counter and output-pin values for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    hi_en_d   = hi_en_q;
    hi_byte_d = hi_byte_q;
    ctrl_d    = cfg_ctrl;
    data_d    = cfg_data;
    pop_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c = 1'b1;
          // An entry with no byte enables is consumed without a transfer.
          if (pop_be != 2'b00) begin
            state_d   = ST_SETUP;
            cnt_d     = CNT_W'(SETUP_CYCLES - 1);
            phase_d   = ~pop_be[0];
            hi_en_d   = pop_be[0] & pop_be[1];
            hi_byte_d = pop_data[15:8];
            ctrl_d    = '0;
            ctrl_d[CFG_ADDR0_BIT] = ~pop_be[0];
            ctrl_d[CFG_ADDR_LSB +: ADDR_BITS] = pop_addr;
            data_d    = pop_be[0] ? pop_data[7:0] : pop_data[15:8];
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_W'(STROBE_CYCLES - 1);
          ctrl_d[CFG_STROBE_BIT] = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          ctrl_d[CFG_STROBE_BIT] = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          // High byte of a full-word write follows its low byte; address is unchanged.
          if (hi_en_q && !phase_q) begin
            state_d = ST_SETUP;
            cnt_d   = CNT_W'(SETUP_CYCLES - 1);
            phase_d = 1'b1;
            hi_en_d = 1'b0;
            ctrl_d[CFG_ADDR0_BIT] = 1'b1;
            data_d  = hi_byte_q;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state and registered pin drivers; reset drops the strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      hi_en_q   <= 1'b0;
      hi_byte_q <= '0;
      cfg_ctrl  <= '0;
      cfg_data  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      hi_en_q   <= hi_en_d;
      hi_byte_q <= hi_byte_d;
      cfg_ctrl  <= ctrl_d;
      cfg_data  <= data_d;
    end
  end

endmodule

// File: tb/tb_cfg_byte_writer.sv
// Directed bench for cfg_byte_writer: default instance plus a minimum-timing
// instance, each looped back into a synth-side config register model.
module tb_cfg_byte_writer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cfg_byte_writer_if #(.ADDR_BITS(3)) wif0 ();
  cfg_byte_writer_if #(.ADDR_BITS(3)) wif1 ();

  logic [7:0] ctrl0, data0, ctrl1, data1;
  logic       busy0, busy1;

  cfg_byte_writer u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wif0),
    .cfg_ctrl (ctrl0),
    .cfg_data (data0),
    .busy     (busy0)
  );

  cfg_byte_writer #(
    .SETUP_CYCLES  (1),
    .STROBE_CYCLES (3),
    .HOLD_CYCLES   (1)
  ) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wif1),
    .cfg_ctrl (ctrl1),
    .cfg_data (data1),
    .busy     (busy1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Synth-side model: 2-flop strobe sync, rising-edge capture into 8 config words.
  logic [7:0]  m_ctrl [2];
  logic [7:0]  m_data [2];
  logic        s1 [2], s2 [2], s3 [2], stb_prev [2];
  logic [15:0] mreg [2][8];
  logic [11:0] mlog [2][64];
  int          mlog_n [2];
  int          pulse_cnt [2];
  int          low_run [2];
  int          min_gap [2];
  logic        seen_hi [2];

  always_comb begin
    m_ctrl[0] = ctrl0;
    m_ctrl[1] = ctrl1;
    m_data[0] = data0;
    m_data[1] = data1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        s1[d] <= 1'b0; s2[d] <= 1'b0; s3[d] <= 1'b0; stb_prev[d] <= 1'b0;
        mlog_n[d] <= 0; pulse_cnt[d] <= 0; low_run[d] <= 0;
        min_gap[d] <= 1000; seen_hi[d] <= 1'b0;
        for (int a = 0; a < 8; a++) mreg[d][a] <= 16'h0000;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        s1[d] <= m_ctrl[d][7];
        s2[d] <= s1[d];
        s3[d] <= s2[d];
        stb_prev[d] <= m_ctrl[d][7];
        if (m_ctrl[d][7] && !stb_prev[d]) pulse_cnt[d] <= pulse_cnt[d] + 1;
        if (s2[d] && !s3[d]) begin
          if (m_ctrl[d][0])
            mreg[d][m_ctrl[d][3:1]] <= {m_data[d], mreg[d][m_ctrl[d][3:1]][7:0]};
          else
            mreg[d][m_ctrl[d][3:1]] <= {mreg[d][m_ctrl[d][3:1]][15:8], m_data[d]};
          mlog[d][mlog_n[d] % 64] <= {m_ctrl[d][3:0], m_data[d]};
          mlog_n[d] <= mlog_n[d] + 1;
        end
        if (m_ctrl[d][7]) begin
          if (seen_hi[d] && low_run[d] > 0 && low_run[d] < min_gap[d]) min_gap[d] <= low_run[d];
          low_run[d] <= 0;
          seen_hi[d] <= 1'b1;
        end else begin
          low_run[d] <= low_run[d] + 1;
        end
      end
    end
  end

  // Bench-side expectations.
  logic [15:0] exp_reg [2][8];
  logic [11:0] exp_log [2][64];
  int          exp_n [2];

  task automatic clear_expect();
    for (int d = 0; d < 2; d++) begin
      exp_n[d] = 0;
      for (int a = 0; a < 8; a++) exp_reg[d][a] = 16'h0000;
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [2:0] a,
                       input logic [15:0] dat, input logic [1:0] be);
    if (d == 0) begin
      wif0.in_valid = v; wif0.in_addr = a; wif0.in_data = dat; wif0.in_be = be;
    end else begin
      wif1.in_valid = v; wif1.in_addr = a; wif1.in_data = dat; wif1.in_be = be;
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? wif0.in_ready : wif1.in_ready;
  endfunction

  function automatic logic bsy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  // One write; returns after the accepting edge (+1ns) with the number of stalled cycles.
  task automatic wr(input int d, input logic [2:0] a, input logic [15:0] dat,
                    input logic [1:0] be, output int stalls);
    stalls = 0;
    @(negedge clk);
    drive(d, 1'b1, a, dat, be);
    while (!rdy(d) && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 200) check("wr_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    drive(d, 1'b0, 3'd0, 16'h0000, 2'b00);
    if (be[0]) begin
      exp_reg[d][a][7:0] = dat[7:0];
      exp_log[d][exp_n[d] % 64] = {a, 1'b0, dat[7:0]};
      exp_n[d]++;
    end
    if (be[1]) begin
      exp_reg[d][a][15:8] = dat[15:8];
      exp_log[d][exp_n[d] % 64] = {a, 1'b1, dat[15:8]};
      exp_n[d]++;
    end
  endtask

  task automatic wait_idle(input int d, input int limit);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while (bsy(d) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= limit) check($sformatf("idle_timeout_d%0d", d), 32'd1, 32'd0);
  endtask

  task automatic compare_log(input int d, input string pfx);
    check($sformatf("%s_nbytes", pfx), 32'(mlog_n[d]), 32'(exp_n[d]));
    for (int i = 0; i < exp_n[d] && i < 64; i++)
      check($sformatf("%s_byte%0d", pfx, i), 32'(mlog[d][i]), 32'(exp_log[d][i]));
  endtask

  task automatic compare_regs(input int d, input string pfx);
    for (int a = 0; a < 8; a++)
      check($sformatf("%s_reg%0d", pfx, a), 32'(mreg[d][a]), 32'(exp_reg[d][a]));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    int          first_stall;
    int          pulse_base;
    logic [7:0]  ec;
    logic [7:0]  ed;
    logic [2:0]  w_addr [6];
    logic [15:0] w_data [6];
    logic [1:0]  w_be   [6];

    rst_n = 1'b0;
    drive(0, 1'b0, 3'd0, 16'h0000, 2'b00);
    drive(1, 1'b0, 3'd0, 16'h0000, 2'b00);
    clear_expect();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 32'(ctrl0), 32'h00);
    check("rst_data", 32'(data0), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", 32'(wif0.in_ready), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_ctrl_after", 32'(ctrl0), 32'h00);

    // Reset asserted while the strobe is high.
    wr(0, 3'd3, 16'h5566, 2'b01, st);
    repeat (3) @(posedge clk);
    #1;
    check("rststb_ctrl_hi", 32'(ctrl0), 32'h86);
    #2;
    rst_n = 1'b0;
    #1;
    check("rststb_strobe_drop", 32'(ctrl0[7]), 32'd0);
    check("rststb_ctrl", 32'(ctrl0), 32'h00);
    check("rststb_ready", 32'(wif0.in_ready), 32'd1);
    check("rststb_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_expect();

    // Full-word write, cycle by cycle from the accepting edge N.
    wr(0, 3'd2, 16'h1234, 2'b11, st);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      if      (k <= 2)  begin ec = 8'h04; ed = 8'h34; end
      else if (k <= 6)  begin ec = 8'h84; ed = 8'h34; end
      else if (k <= 8)  begin ec = 8'h04; ed = 8'h34; end
      else if (k <= 10) begin ec = 8'h05; ed = 8'h12; end
      else if (k <= 14) begin ec = 8'h85; ed = 8'h12; end
      else              begin ec = 8'h05; ed = 8'h12; end
      check($sformatf("t2_ctrl_n%0d", k), 32'(ctrl0), 32'(ec));
      check($sformatf("t2_data_n%0d", k), 32'(data0), 32'(ed));
      check($sformatf("t2_busy_n%0d", k), 32'(busy0), (k < 17) ? 32'd1 : 32'd0);
    end

    // High byte only.
    wr(0, 3'd5, 16'hAB00, 2'b10, st);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      ec = (k >= 3 && k <= 6) ? 8'h8B : 8'h0B;
      check($sformatf("t3_ctrl_n%0d", k), 32'(ctrl0), 32'(ec));
      check($sformatf("t3_data_n%0d", k), 32'(data0), 32'hAB);
      check($sformatf("t3_busy_n%0d", k), 32'(busy0), (k < 9) ? 32'd1 : 32'd0);
    end

    // No byte enables: accepted, discarded, no strobe.
    pulse_base = pulse_cnt[0];
    wr(0, 3'd4, 16'hFFFF, 2'b00, st);
    check("t3_be00_accept_stalls", 32'(st), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("t3_be00_busy", 32'(busy0), 32'd0);
    check("t3_be00_ctrl_kept", 32'(ctrl0), 32'h0B);
    check("t3_be00_data_kept", 32'(data0), 32'hAB);
    repeat (8) @(posedge clk);
    #1;
    check("t3_be00_no_pulse", 32'(pulse_cnt[0] - pulse_base), 32'd0);

    // Six back-to-back words into a depth-4 FIFO. The first entry is popped the
    // edge after it is pushed, so five are accepted before in_ready drops.
    w_addr = '{3'd0, 3'd1, 3'd6, 3'd7, 3'd3, 3'd4};
    w_data = '{16'hC3A5, 16'h00E1, 16'h9F00, 16'h5A5A, 16'h0077, 16'hBEEF};
    w_be   = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11};
    first_stall = -1;
    for (int i = 0; i < 6; i++) begin
      wr(0, w_addr[i], w_data[i], w_be[i], st);
      if (st > 0 && first_stall < 0) first_stall = i;
    end
    check("t4_first_stall_word", 32'(first_stall), 32'd5);
    wait_idle(0, 400);
    compare_log(0, "t4");

    // Loopback: eight full words, then partial writes on top.
    for (int a = 0; a < 8; a++)
      wr(0, 3'(a), 16'hA501 + 16'(a) * 16'h1111, 2'b11, st);
    wr(0, 3'd1, 16'hFFAA, 2'b01, st);
    wr(0, 3'd6, 16'h77FF, 2'b10, st);
    wr(0, 3'd3, 16'h0000, 2'b00, st);
    wait_idle(0, 1000);
    repeat (6) @(posedge clk);
    compare_regs(0, "t5");
    compare_log(0, "t5");
    check("t5_min_gap", 32'(min_gap[0]), 32'd4);

    // Minimum-legal timing instance.
    for (int a = 0; a < 8; a++)
      wr(1, 3'(a), 16'h0F3C + 16'(a) * 16'h2468, 2'b11, st);
    wr(1, 3'd2, 16'h5511, 2'b01, st);
    wr(1, 3'd5, 16'hEE22, 2'b10, st);
    wr(1, 3'd0, 16'h1234, 2'b00, st);
    wait_idle(1, 1000);
    repeat (6) @(posedge clk);
    compare_regs(1, "t6");
    compare_log(1, "t6");
    check("t6_min_gap", 32'(min_gap[1]), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
